// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts an operand one bit per clock until it is MSB- or
// LSB-justified, reporting the shift count in the shifter's RLamount encoding.
module shift_normalizer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        dir,
   input  logic [15:0] in,
   output logic        busy,
   output logic        done,
   output logic [15:0] out,
   output logic [4:0]  RLamount,
   output logic        zero
);

   localparam int unsigned WIDTH = 16;
   localparam int unsigned AMT_W = 5;
   localparam int unsigned CNT_W = AMT_W - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   data;
   logic [CNT_W-1:0]   count;
   logic               dir_q;
   logic               target_set;

   // Bit that must be set for the operand to count as normalized in the current mode.
   assign target_set = dir_q ? data[0] : data[WIDTH-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         out      <= '0;
         RLamount <= '0;
         zero     <= 1'b0;
         data     <= '0;
         count    <= '0;
         dir_q    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  data  <= in;
                  dir_q <= dir;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (data == '0) begin
                  zero     <= 1'b1;
                  out      <= '0;
                  RLamount <= {dir_q, CNT_W'(0)};
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (target_set) begin
                  zero     <= 1'b0;
                  out      <= data;
                  RLamount <= {dir_q, count};
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  data <= dir_q ? (data >> 1) : (data << 1);
                  // Cannot exceed 15 for a nonzero operand; saturate anyway.
                  if (count != CNT_W'(WIDTH - 1))
                     count <= count + CNT_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and swept checks of shift_normalizer: results, latency, busy window,
// start-while-busy rejection, back-to-back acceptance and async reset.
module tb_shift_normalizer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        dir;
   logic [15:0] din;
   logic        busy;
   logic        done;
   logic [15:0] dout;
   logic [4:0]  RLamount;
   logic        zero;

   int errors;
   int checks;

   shift_normalizer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .dir      (dir),
      .in       (din),
      .busy     (busy),
      .done     (done),
      .out      (dout),
      .RLamount (RLamount),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected shift count: leading zeros (left) or trailing zeros (right).
   function automatic int exp_k(input logic d, input logic [15:0] v);
      if (v == 16'h0000) return 0;
      if (!d) begin
         for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
      end else begin
         for (int i = 0; i < 16; i++) if (v[i]) return i;
      end
      return 0;
   endfunction

   // Issue one request; returns cycles from the accepting edge to done and busy-cycle count.
   task automatic do_req(input logic d, input logic [15:0] v, output int lat, output int bc);
      @(negedge clk);
      start = 1'b1;
      dir   = d;
      din   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      bc  = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bc++;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL timeout: done not seen within %0d cycles for in=%h dir=%0d", lat, v, d);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      dir     = 1'b0;
      din     = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, dout, RLamount, zero} !== {1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b out=%h amt=%b zero=%b, want all zero",
                  busy, done, dout, RLamount, zero);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_left_max();
      int lat, bc;
      do_req(1'b0, 16'h0001, lat, bc);
      checks++;
      if (lat !== 16 || bc !== 16) begin
         errors++;
         $display("FAIL left_max_timing: latency=%0d busy_cycles=%0d, want 16 16", lat, bc);
      end
      checks++;
      if (dout !== 16'h8000 || RLamount !== 5'b01111 || zero !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL left_max_result: out=%h amt=%b zero=%b busy=%b, want 8000 01111 0 0",
                  dout, RLamount, zero, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle: done=%b, want 0", done);
      end
   endtask

   task automatic test_already_normalized();
      int lat, bc;
      do_req(1'b0, 16'h8000, lat, bc);
      checks++;
      if (lat !== 1 || dout !== 16'h8000 || RLamount !== 5'b00000) begin
         errors++;
         $display("FAIL left_norm: latency=%0d out=%h amt=%b, want 1 8000 00000", lat, dout, RLamount);
      end
   endtask

   task automatic test_right();
      int lat, bc;
      do_req(1'b1, 16'h0100, lat, bc);
      checks++;
      if (lat !== 9 || dout !== 16'h0001 || RLamount !== 5'b11000 || zero !== 1'b0) begin
         errors++;
         $display("FAIL right_0100: latency=%0d out=%h amt=%b zero=%b, want 9 0001 11000 0",
                  lat, dout, RLamount, zero);
      end
   endtask

   task automatic test_zero();
      int lat, bc;
      for (int d = 0; d < 2; d++) begin
         do_req(1'(d), 16'h0000, lat, bc);
         checks++;
         if (lat !== 1 || zero !== 1'b1 || dout !== 16'h0000 || RLamount[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL zero_dir%0d: latency=%0d zero=%b out=%h amt=%b, want 1 1 0000 x0000",
                     d, lat, zero, dout, RLamount);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      start = 1'b1;
      dir   = 1'b0;
      din   = 16'h0010;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      din   = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      din   = 16'h0000;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore: busy=%b done=%b, want 1 0", busy, done);
      end
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (done !== 1'b1 || dout !== 16'h8000 || RLamount !== 5'b01011) begin
         errors++;
         $display("FAIL ignored_start_result: done=%b out=%h amt=%b, want 1 8000 01011",
                  done, dout, RLamount);
      end
      // Still inside the done cycle: request is accepted at the next edge.
      start = 1'b1;
      dir   = 1'b0;
      din   = 16'h4000;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 2 || done !== 1'b1 || dout !== 16'h8000 || RLamount !== 5'b00001) begin
         errors++;
         $display("FAIL back_to_back: latency=%0d done=%b out=%h amt=%b, want 2 1 8000 00001",
                  lat, done, dout, RLamount);
      end
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      @(negedge clk);
      start = 1'b1;
      dir   = 1'b0;
      din   = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dout !== 16'h0000 || RLamount !== 5'b00000) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b out=%h amt=%b, want 0 0 0000 00000",
                  busy, done, dout, RLamount);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL no_done_after_reset: active_cycles=%0d, want 0", seen);
      end
   endtask

   task automatic test_sweep();
      int lat, bc, k;
      logic [15:0] v, want;
      logic d;
      for (int n = 0; n < 1000; n++) begin
         v = 16'($urandom);
         if (n % 4 == 1) v = v >> $urandom_range(15, 0);
         if (n % 4 == 2) v = v << $urandom_range(15, 0);
         d = 1'(n % 2);
         k = exp_k(d, v);
         want = d ? (v >> k) : (v << k);
         do_req(d, v, lat, bc);
         checks++;
         if (dout !== want || RLamount !== {d, 4'(k)} || lat !== k + 1 || bc !== k + 1
             || zero !== (v == 16'h0000)) begin
            errors++;
            $display("FAIL sweep in=%h dir=%0d: out=%h amt=%b lat=%0d busy=%0d zero=%b, want %h %b %0d %0d %b",
                     v, d, dout, RLamount, lat, bc, zero, want, {d, 4'(k)}, k + 1, k + 1,
                     (v == 16'h0000));
         end
         checks++;
         if (v != 16'h0000 && (d ? dout[0] : dout[15]) !== 1'b1) begin
            errors++;
            $display("FAIL sweep_norm_bit in=%h dir=%0d: out=%h not normalized", v, d, dout);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_left_max();
      test_already_normalized();
      test_right();
      test_zero();
      test_back_to_back();
      test_reset_mid_shift();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
